// File: rtl/w80386_bus_read_responder.sv
// Bus read target for the w80386 core: word-addressed memory with programmable wait states
// and a side load port for boot images.
module w80386_bus_read_responder #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned WAIT_STATES   = 1,
    parameter logic [31:0] OPEN_BUS_DATA = 32'hFFFF_FFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bus_read_vaild,
    input  logic [31:0]           bus_read_address,
    output logic                  bus_read_ready,
    output logic [31:0]           bus_read_data,
    output logic                  bus_read_error,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_index,
    input  logic [31:0]           load_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q;
    logic [3:0]            count_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  oor_q;

    logic [31:0]           mem [Depth];

    logic [ADDR_WIDTH-1:0] req_index;
    logic                  req_oor;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic                  rd_oor;
    logic                  resp_load;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus_read_address[1:0];

    always_comb begin
        req_index = bus_read_address[ADDR_WIDTH+1:2];
        req_oor   = |bus_read_address[31:ADDR_WIDTH+2];
        // In IDLE the response can only be loaded with zero wait states, straight from the bus.
        rd_index  = (state_q == StIdle) ? req_index : index_q;
        rd_oor    = (state_q == StIdle) ? req_oor : oor_q;
        resp_load = 1'b0;
        if (bus_read_vaild) begin
            if (state_q == StIdle && WAIT_STATES == 0) begin
                resp_load = 1'b1;
            end else if (state_q == StWait && count_q == 4'd1) begin
                resp_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            count_q        <= 4'd0;
            index_q        <= '0;
            oor_q          <= 1'b0;
            bus_read_ready <= 1'b0;
            bus_read_error <= 1'b0;
            bus_read_data  <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_read_vaild) begin
                        index_q <= req_index;
                        oor_q   <= req_oor;
                        if (WAIT_STATES == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            count_q <= 4'(WAIT_STATES);
                        end
                    end
                end
                StWait: begin
                    if (!bus_read_vaild) begin
                        state_q <= StIdle;
                        count_q <= 4'd0;
                    end else if (count_q == 4'd1) begin
                        state_q <= StResp;
                        count_q <= 4'd0;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q        <= StIdle;
                    bus_read_ready <= 1'b0;
                    bus_read_error <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase

            // Memory read sees the pre-edge word, so a same-edge load returns the old contents.
            if (resp_load) begin
                bus_read_ready <= 1'b1;
                bus_read_error <= rd_oor;
                bus_read_data  <= rd_oor ? OPEN_BUS_DATA : mem[rd_index];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        if (load_enable) begin
            mem[load_index] <= load_data;
        end
    end

endmodule

// File: tb/tb_w80386_bus_read_responder.sv
// Scoreboard bench for w80386_bus_read_responder: one instance with zero and one with three wait
// states, directed requests push expected responses, per-instance monitors pop and compare.
module tb_w80386_bus_read_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        v0, v3;
    logic [31:0] a0, a3;
    logic        r0, r3, e0, e3;
    logic [31:0] d0, d3;
    logic        le;
    logic [9:0]  li;
    logic [31:0] ld;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    w80386_bus_read_responder #(
        .ADDR_WIDTH(10), .WAIT_STATES(0), .OPEN_BUS_DATA(32'hFFFF_FFFF)
    ) u_dut0 (
        .clock(clock), .reset(reset),
        .bus_read_vaild(v0), .bus_read_address(a0),
        .bus_read_ready(r0), .bus_read_data(d0), .bus_read_error(e0),
        .load_enable(le), .load_index(li), .load_data(ld)
    );

    w80386_bus_read_responder #(
        .ADDR_WIDTH(10), .WAIT_STATES(3), .OPEN_BUS_DATA(32'hFFFF_FFFF)
    ) u_dut3 (
        .clock(clock), .reset(reset),
        .bus_read_vaild(v3), .bus_read_address(a3),
        .bus_read_ready(r3), .bus_read_data(d3), .bus_read_error(e3),
        .load_enable(le), .load_index(li), .load_data(ld)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clock) begin : mon0
        exp_t e;
        if (r0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ready0_unexpected: got ready=1 at cycle %0d required none", cyc);
            end else begin
                e = q0.pop_front();
                chk("data0", d0, e.data);
                chk("error0", {31'd0, e0}, {31'd0, e.err});
                chk("latency0", 32'(cyc), 32'(e.at));
            end
        end else if (e0) begin
            checks++;
            errors++;
            $display("FAIL error0_without_ready: got error=1 ready=0 at cycle %0d", cyc);
        end
    end

    always @(negedge clock) begin : mon3
        exp_t e;
        if (r3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ready3_unexpected: got ready=1 at cycle %0d required none", cyc);
            end else begin
                e = q3.pop_front();
                chk("data3", d3, e.data);
                chk("error3", {31'd0, e3}, {31'd0, e.err});
                chk("latency3", 32'(cyc), 32'(e.at));
            end
        end else if (e3) begin
            checks++;
            errors++;
            $display("FAIL error3_without_ready: got error=1 ready=0 at cycle %0d", cyc);
        end
    end

    // Called #1 after a rising edge.
    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        le = 1'b1;
        li = idx;
        ld = data;
        @(posedge clock);
        #1 le = 1'b0;
    endtask

    // Called #1 after a rising edge with the target idle; the next edge samples the request.
    task automatic rd(input int sel, input logic [31:0] addr, input logic [31:0] exp,
                      input logic err, input bit hold);
        exp_t e;
        int   ws;
        bit   seen;
        ws     = (sel == 0) ? 0 : 3;
        e.data = exp;
        e.err  = err;
        e.at   = cyc + 1 + ws;
        if (sel == 0) begin
            v0 = 1'b1;
            a0 = addr;
            q0.push_back(e);
        end else begin
            v3 = 1'b1;
            a3 = addr;
            q3.push_back(e);
        end
        @(posedge clock);
        #1 le = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = (sel == 0) ? r0 : r3;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: dut%0d addr %h got no ready required ready", ws, addr);
        end
        @(posedge clock);
        #1;
        if (!hold) begin
            v0 = 1'b0;
            v3 = 1'b0;
        end
    endtask

    initial begin
        v0 = 1'b0; v3 = 1'b0; a0 = '0; a3 = '0;
        le = 1'b0; li = '0; ld = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready0", {31'd0, r0}, 32'd0);
        chk("rst_error0", {31'd0, e0}, 32'd0);
        chk("rst_data0", d0, 32'd0);
        chk("rst_ready3", {31'd0, r3}, 32'd0);
        chk("rst_error3", {31'd0, e3}, 32'd0);
        chk("rst_data3", d3, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("post_rst_ready0", {31'd0, r0}, 32'd0);
        chk("post_rst_ready3", {31'd0, r3}, 32'd0);

        load(10'd5, 32'hDEAD_BEEF);
        load(10'd0, 32'hA5A5_0001);
        load(10'd1, 32'h5A5A_0002);
        load(10'd2, 32'h1111_1111);

        // Zero wait states, out of range, unaligned address.
        rd(0, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rd(0, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rd(0, 32'h0000_0017, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Three wait states, back-to-back with valid held.
        rd(3, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 1'b1);
        rd(3, 32'h0000_0004, 32'h5A5A_0002, 1'b0, 1'b0);
        rd(3, 32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Abort in WAIT: no ready, last response held.
        v3 = 1'b1;
        a3 = 32'h0000_0014;
        repeat (2) @(posedge clock);
        #1 v3 = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("abort_hold_data3", d3, 32'hFFFF_FFFF);
        chk("abort_ready3", {31'd0, r3}, 32'd0);

        // Reset during WAIT of a second request.
        v3 = 1'b1;
        a3 = 32'h0000_0000;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("midrst_data3", d3, 32'd0);
        chk("midrst_ready3", {31'd0, r3}, 32'd0);
        chk("midrst_error3", {31'd0, e3}, 32'd0);
        v3 = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rd(3, 32'h0000_0004, 32'h5A5A_0002, 1'b0, 1'b0);

        // Collision: same-edge load returns the old word, later read sees the new one.
        le = 1'b1;
        li = 10'd2;
        ld = 32'h2222_2222;
        rd(0, 32'h0000_0008, 32'h1111_1111, 1'b0, 1'b0);
        rd(0, 32'h0000_0008, 32'h2222_2222, 1'b0, 1'b0);

        repeat (5) @(posedge clock);
        #1;
        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue3_drained", 32'(q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
